mux4_scan: RTL and testbench

- Sequencer that sits directly upstream of the 4:1 multiplexer (mux4_1).
- Drives the mux select, waits a programmable settle time on each channel, and samples the mux output.
- Assembles the four sampled bits (a, b, c, d) into one 4-bit word and hands it downstream with a valid/ready handshake.
- Turns the combinational mux into a time-multiplexed 4-channel serial-to-parallel capture stage.

---
 rtl/mux4_scan_pkg.sv | 23 ++
 rtl/mux4_scan_if.sv | 23 ++
 rtl/mux4_scan_dwell_timer.sv | 28 ++
 rtl/mux4_scan.sv | 120 ++++++++++++
 tb/tb_mux4_scan.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux4_scan_pkg.sv
// rtl/mux4_scan_pkg.sv - shared types, select constants and dwell legality check for mux4_scan
package mux4_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [1:0] sel_t;
  typedef logic [3:0] word_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;
  localparam sel_t SEL_D = 2'd3;

  // Counter width must hold DWELL-1 without wrapping.
  function automatic bit dwell_ok(input int dwell, input int cw);
    return (dwell >= 1) && (dwell <= 255) && (cw >= 1) && (cw <= 30) && ((1 << cw) > dwell);
  endfunction

endpackage

// File: rtl/mux4_scan_if.sv
// rtl/mux4_scan_if.sv - control, mux and word handshake signals of mux4_scan
interface mux4_scan_if;
  import mux4_scan_pkg::*;

  logic  start;
  logic  clear;
  logic  mux_out;
  logic  ready;
  sel_t  s;
  logic  busy;
  word_t word;
  logic  valid;

  modport master (
    input  start, clear, mux_out, ready,
    output s, busy, word, valid
  );

  modport slave (
    output start, clear, mux_out, ready,
    input  s, busy, word, valid
  );
endinterface

// File: rtl/mux4_scan_dwell_timer.sv
// rtl/mux4_scan_dwell_timer.sv - loadable down-counter timing how long each select is held
module dwell_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt;

  // Saturates at zero; the FSM reloads before another dwell begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux4_scan.sv
// rtl/mux4_scan.sv - steps a 4:1 mux select, samples each channel after a dwell, hands out a 4-bit word
module mux4_scan
  import mux4_scan_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         reset,
  mux4_scan_if.master  bus
);

  if (!dwell_ok(DWELL, CW)) begin : g_bad_dwell
    $error("mux4_scan: DWELL must be 1..255 and fit in CW bits");
  end

  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  state_t        state, state_n;
  sel_t          s_q, s_n;
  word_t         word_q, word_n;
  logic          valid_q, valid_n;
  logic          busy_q, busy_n;
  logic          load, en, zero;
  logic [CW-1:0] load_val;

  dwell_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .en       (en),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      s_q     <= SEL_A;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      s_q     <= s_n;
      word_q  <= word_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_n      = s_q;
    word_n   = word_q;
    valid_n  = valid_q;
    busy_n   = busy_q;
    load     = 1'b0;
    en       = 1'b0;
    load_val = RELOAD;

    if (bus.clear) begin
      // Abort keeps the partially captured word; only control state is reset.
      state_n  = S_IDLE;
      s_n      = SEL_A;
      valid_n  = 1'b0;
      busy_n   = 1'b0;
      load     = 1'b1;
      load_val = '0;
    end else begin
      case (state)
        S_IDLE: begin
          s_n = SEL_A;
          if (bus.start) begin
            state_n = S_SCAN;
            busy_n  = 1'b1;
            load    = 1'b1;
          end
        end
        S_SCAN: begin
          if (!zero) begin
            en = 1'b1;
          end else begin
            word_n[s_q] = bus.mux_out;
            if (s_q == SEL_D) begin
              state_n = S_DONE;
              valid_n = 1'b1;
            end else begin
              s_n  = s_q + 2'd1;
              load = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.ready) begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            state_n = S_IDLE;
            s_n     = SEL_A;
            // Restart in the handshake cycle so back-to-back scans have no bubble.
            if (bus.start) begin
              state_n = S_SCAN;
              busy_n  = 1'b1;
              load    = 1'b1;
            end
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  assign bus.s     = s_q;
  assign bus.word  = word_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux4_scan.sv
// tb/tb_mux4_scan.sv - scoreboard bench for mux4_scan with DWELL=2 and DWELL=1 instances
module tb_mux4_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] chan2, chan1;
  logic [3:0] model_word2;
  logic [3:0] sb2[$];
  logic [3:0] sb1[$];
  int         tests = 0;
  int         fails = 0;

  mux4_scan_if if2 ();
  mux4_scan_if if1 ();

  assign if2.mux_out = chan2[if2.s];
  assign if1.mux_out = chan1[if1.s];

  mux4_scan #(.DWELL(2), .CW(8)) dut2 (.clk(clk), .reset(reset), .bus(if2));
  mux4_scan #(.DWELL(1), .CW(8)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_valid(input bit d1);
    return d1 ? if1.valid : if2.valid;
  endfunction
  function automatic logic get_busy(input bit d1);
    return d1 ? if1.busy : if2.busy;
  endfunction
  function automatic logic [1:0] get_s(input bit d1);
    return d1 ? if1.s : if2.s;
  endfunction
  function automatic logic [3:0] get_word(input bit d1);
    return d1 ? if1.word : if2.word;
  endfunction

  task automatic drive_start(input bit d1, input logic v);
    if (d1) if1.start = v; else if2.start = v;
  endtask
  task automatic drive_ready(input bit d1, input logic v);
    if (d1) if1.ready = v; else if2.ready = v;
  endtask

  // Scoreboard monitor: every handshake pops the oldest expected word.
  always @(negedge clk) begin
    if (reset && if2.valid && if2.ready) begin
      if (sb2.size() == 0) chk("sb2_unexpected", 1, 0);
      else chk("sb2_word", if2.word, sb2.pop_front());
    end
    if (reset && if1.valid && if1.ready) begin
      if (sb1.size() == 0) chk("sb1_unexpected", 1, 0);
      else chk("sb1_word", if1.word, sb1.pop_front());
    end
  end

  // Reference: word bit i is channel i; valid after 4*DWELL edges; s = t/DWELL capped at 3.
  task automatic scan(input bit d1, input logic [3:0] ch, input int rdy_delay, input bit check_s);
    int dw;
    int t;
    dw = d1 ? 1 : 2;
    if (d1) begin
      chan1 = ch;
      sb1.push_back(ch);
    end else begin
      chan2 = ch;
      sb2.push_back(ch);
      model_word2 = ch;
    end
    drive_start(d1, 1'b1);
    drive_ready(d1, rdy_delay == 0);
    tick();
    drive_start(d1, 1'b0);
    t = 0;
    while (!get_valid(d1) && t < 40) begin
      if (check_s) chk("s_step", get_s(d1), (t / dw > 3) ? 3 : t / dw);
      tick();
      t++;
    end
    chk("latency", t, 4 * dw);
    if (check_s) chk("s_done", get_s(d1), 3);
    chk("busy_in_done", get_busy(d1), 1);
    for (int i = 0; i < rdy_delay; i++) begin
      chk("valid_hold", get_valid(d1), 1);
      chk("word_hold", get_word(d1), ch);
      tick();
    end
    drive_ready(d1, 1'b1);
    tick();
    drive_ready(d1, 1'b0);
    chk("valid_after_hs", get_valid(d1), 0);
    chk("busy_after_hs", get_busy(d1), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ch, ch_b, exp_w;
    int         t;
    bit         seen;

    reset = 1'b0;
    chan2 = '0;
    chan1 = '0;
    model_word2 = '0;
    if2.start = 1'b0; if2.clear = 1'b0; if2.ready = 1'b0;
    if1.start = 1'b0; if1.clear = 1'b0; if1.ready = 1'b0;
    tick();
    tick();
    chk("rst_s", if2.s, 0);
    chk("rst_word", if2.word, 0);
    chk("rst_valid", if2.valid, 0);
    chk("rst_busy", if2.busy, 0);
    reset = 1'b1;
    tick();

    // Test 1: a=1 b=0 c=1 d=0, ready already high
    scan(1'b0, 4'b0101, 0, 1'b1);

    // Test 2: a=0 b=1 c=1 d=1, ready withheld for 5 cycles
    scan(1'b0, 4'b1110, 5, 1'b0);

    // Test 3: asynchronous reset mid-scan
    chan2 = 4'($urandom_range(0, 15));
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_s", if2.s, 0);
    chk("arst_valid", if2.valid, 0);
    chk("arst_busy", if2.busy, 0);
    chk("arst_word", if2.word, 0);
    model_word2 = '0;
    #2;
    reset = 1'b1;
    tick();
    scan(1'b0, 4'($urandom_range(0, 15)), 0, 1'b1);

    // Test 4: clear while s == 2 keeps bits already sampled
    ch = 4'($urandom_range(0, 15));
    chan2 = ch;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("clr_pre_s", if2.s, 2);
    if2.clear = 1'b1;
    tick();
    if2.clear = 1'b0;
    chk("clr_s", if2.s, 0);
    chk("clr_busy", if2.busy, 0);
    chk("clr_valid", if2.valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if2.valid) seen = 1'b1;
      tick();
    end
    chk("clr_no_valid", seen, 0);
    exp_w = {model_word2[3:2], ch[1:0]};
    chk("clr_word_kept", if2.word, exp_w);
    model_word2 = exp_w;
    scan(1'b0, 4'($urandom_range(0, 15)), 1, 1'b0);

    // Test 5: start held high through the handshake gives back-to-back scans
    ch = 4'($urandom_range(0, 15));
    ch_b = ~ch;
    chan2 = ch;
    sb2.push_back(ch);
    if2.start = 1'b1;
    if2.ready = 1'b1;
    tick();
    t = 0;
    while (!if2.valid && t < 40) begin tick(); t++; end
    chk("b2b_latency1", t, 8);
    tick();
    chan2 = ch_b;
    sb2.push_back(ch_b);
    chk("b2b_busy", if2.busy, 1);
    chk("b2b_valid_low", if2.valid, 0);
    chk("b2b_s", if2.s, 0);
    t = 0;
    while (!if2.valid && t < 40) begin tick(); t++; end
    chk("b2b_latency2", t, 8);
    if2.start = 1'b0;
    tick();
    if2.ready = 1'b0;
    chk("b2b_idle_busy", if2.busy, 0);

    // Test 6: DWELL=1 instance, all channels high
    scan(1'b1, 4'b1111, 0, 1'b1);

    // Random scans on both instances
    for (int i = 0; i < 6; i++) begin
      scan(1'b0, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      scan(1'b1, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b1);
    end

    tick();
    chk("sb2_drained", sb2.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
